// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the CPU blocks and their benches.
//   INSTR_ADDR_WIDTH / INSTR_WIDTH : instruction store geometry.
//   NOP_INSTR                      : filler word for the unused store region.
//   PROG_WORD_0..PROG_WORD_4       : default boot program.
//   default_word(addr)             : boot image word at any word address.
package cpu_pkg;

    localparam int unsigned INSTR_ADDR_WIDTH = 8;
    localparam int unsigned INSTR_WIDTH      = 32;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [INSTR_WIDTH-1:0] PROG_WORD_0 = 32'h2001_0005;
    localparam logic [INSTR_WIDTH-1:0] PROG_WORD_1 = 32'h2002_0003;
    localparam logic [INSTR_WIDTH-1:0] PROG_WORD_2 = 32'h0022_1820;
    localparam logic [INSTR_WIDTH-1:0] PROG_WORD_3 = 32'hAC03_0000;
    localparam logic [INSTR_WIDTH-1:0] PROG_WORD_4 = 32'h8C04_0000;

    function automatic logic [INSTR_WIDTH-1:0] default_word(input int unsigned addr);
        logic [INSTR_WIDTH-1:0] word;
        word = NOP_INSTR;
        case (addr)
            0:       word = PROG_WORD_0;
            1:       word = PROG_WORD_1;
            2:       word = PROG_WORD_2;
            3:       word = PROG_WORD_3;
            4:       word = PROG_WORD_4;
            default: word = NOP_INSTR;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// instruction_memory: 2**ADDR_WIDTH x DATA_WIDTH instruction store for the fetch stage.
//   clk         : write clock (rising edge).
//   rst_n       : asynchronous active-low reset, restores the boot image.
//   address     : fetch word address; instruction is driven combinationally.
//   instruction : word at address.
//   load_en     : load-port write enable.
//   load_addr   : load-port word address.
//   load_data   : load-port write data.
//
// The boot image is not copied into the array. Each word carries a "loaded" flag;
// while clear, the read returns default_word(address). Reset only clears the
// flags, which restores the whole image instantly and without touching the data
// array. The flags start cleared at time zero so the block works without a reset.
module instruction_memory
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = INSTR_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = INSTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] instruction,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      loaded_q = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded_q <= '0;
        end else if (load_en) begin
            loaded_q[load_addr] <= 1'b1;
        end
    end

    // Data array needs no reset: its words are only visible once flagged loaded.
    // The rst_n term keeps a write from landing on an edge while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_comb begin
        instruction = DATA_WIDTH'(default_word(32'(address)));
        if (loaded_q[address]) begin
            instruction = mem_q[address];
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic [7:0]  address   = 8'd0;
    logic        load_en   = 1'b0;
    logic [7:0]  load_addr = 8'd0;
    logic [31:0] load_data = 32'd0;
    logic [31:0] instruction;

    instruction_memory #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .instruction (instruction),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data)
    );

    always #5 clk = ~clk;

    // Reference memory and scoreboard.
    logic [31:0] model [256];
    logic [31:0] exp_q [$];
    string       tag_q [$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model[i] = 32'h0000_0000;
        model[0] = 32'h2001_0005;
        model[1] = 32'h2002_0003;
        model[2] = 32'h0022_1820;
        model[3] = 32'hAC03_0000;
        model[4] = 32'h8C04_0000;
    endtask

    task automatic compare_next();
        logic [31:0] exp;
        string       tag;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            check_eq(tag, instruction, exp);
        end
    endtask

    // Drive a fetch address, queue its expected word, compare after settling.
    task automatic read_at(input logic [7:0] a, input string tag);
        address = a;
        exp_q.push_back(model[a]);
        tag_q.push_back(tag);
        #1;
        compare_next();
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk);
        if (rst_n) model[a] = d;
        #1;
        load_en = 1'b0;
    endtask

    initial begin
        model_reset();

        // Usable before any reset.
        #2;
        read_at(8'd0, "pre_reset_a0");
        read_at(8'd4, "pre_reset_a4");

        // Reset pulse.
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();

        // Default fetch, stepped with no load activity.
        for (int i = 0; i < 5; i++) begin
            read_at(8'(i), $sformatf("default_a%0d", i));
            #9;
        end

        // Unused region.
        read_at(8'd5,   "nop_a5");
        read_at(8'd128, "nop_a128");
        read_at(8'd255, "nop_a255");

        // Single load.
        load_word(8'd10, 32'hDEAD_BEEF);
        read_at(8'd10, "load_a10");
        read_at(8'd9,  "load_neighbour_a9");
        read_at(8'd11, "load_neighbour_a11");

        // Top address.
        load_word(8'd255, 32'hA5A5_5A5A);
        read_at(8'd255, "load_a255");
        read_at(8'd254, "load_neighbour_a254");

        // Read-during-write, same address.
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 8'd2;
        load_data = 32'h1234_5678;
        read_at(8'd2, "rdw_before_edge");
        @(posedge clk);
        model[2] = 32'h1234_5678;
        #1;
        load_en = 1'b0;
        read_at(8'd2, "rdw_after_edge");

        // Write at one address while fetching another.
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 8'd20;
        load_data = 32'h0BAD_CAFE;
        read_at(8'd1, "indep_fetch_a1");
        @(posedge clk);
        model[20] = 32'h0BAD_CAFE;
        #1;
        load_en = 1'b0;
        read_at(8'd1,  "indep_after_a1");
        read_at(8'd20, "indep_after_a20");

        // Overwrite word 0, then reset asynchronously mid-cycle with load_en high.
        load_word(8'd0, 32'hCAFE_F00D);
        read_at(8'd0, "overwrite_a0");
        @(negedge clk);
        #2;
        load_en   = 1'b1;
        load_addr = 8'd0;
        load_data = 32'hFFFF_FFFF;
        rst_n     = 1'b0;
        model_reset();
        read_at(8'd0,  "reset_async_a0");
        read_at(8'd10, "reset_async_a10");
        read_at(8'd2,  "reset_async_a2");
        @(posedge clk);
        #1;
        read_at(8'd0, "reset_hold_a0");
        @(negedge clk);
        load_en = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        read_at(8'd0,   "post_reset_a0");
        read_at(8'd10,  "post_reset_a10");
        read_at(8'd255, "post_reset_a255");

        // Load port disabled: no writes whatever the address/data.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            load_addr = 8'(k);
            load_data = $urandom;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) read_at(8'(i), $sformatf("disabled_a%0d", i));

        // Short random load/fetch mix against the model.
        for (int k = 0; k < 20; k++) begin
            load_word(8'($urandom_range(0, 255)), $urandom);
            read_at(8'($urandom_range(0, 255)), "random_fetch");
            read_at(load_addr, "random_loaded");
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
- 256 x 32-bit instruction store for the CPU fetch stage.
- The program counter's word address drives `address`; the instruction comes out combinationally, zero cycles of latency.
- Holds a fixed default boot program that is restored on reset.
- A synchronous load port lets a loader or bench overwrite words.

Parameters:
- ADDR_WIDTH, 8, word-address width; depth = 2**ADDR_WIDTH = 256 words.
- DATA_WIDTH, 32, instruction width in bits.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; restores the default program image.
- address  input  ADDR_WIDTH  fetch word address (word-indexed, not byte-indexed).
- instruction  output  DATA_WIDTH  contents of the word at `address`, combinational.
- load_en  input  1  write enable for the load port.
- load_addr  input  ADDR_WIDTH  word address to write.
- load_data  input  DATA_WIDTH  word to write.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Storage: array mem[0..255] of DATA_WIDTH bits.
- Read path:
  - instruction = mem[address], purely combinational, no clock needed.
  - Output updates within the same delta/propagation time as an `address` change.
- Default image, loaded while rst_n = 0:
  - mem[0] = 32'h20010005
  - mem[1] = 32'h20020003
  - mem[2] = 32'h00221820
  - mem[3] = 32'hAC030000
  - mem[4] = 32'h8C040000
  - mem[5..255] = 32'h00000000 (NOP)
- Reset:
  - Asserting rst_n low immediately forces every word to the default image, independent of clk.
  - During reset, `instruction` shows default[address].
  - Reset asserted mid-operation discards all loaded words.
- Write:
  - On posedge clk with rst_n = 1 and load_en = 1: mem[load_addr] <= load_data.
  - load_en = 0: no change.
  - Writes are ignored while rst_n = 0 (reset dominates).
- Read-during-write, same address:
  - Before the edge, `instruction` shows the old value.
  - After the edge, it shows load_data, with no extra cycle.
- Write and read at different addresses are independent.
- Address coverage: all 256 addresses are valid; no out-of-range case exists. Address 255 is read and written like any other word.
- No X on `instruction` after the first reset for any address.
- Before the first reset, contents are also initialised to the default image at time zero, so the block is usable with rst_n held high from start.

Decomposition:
- Shared package `cpu_pkg`:
  - INSTR_ADDR_WIDTH = 8, INSTR_WIDTH = 32.
  - NOP_INSTR = 32'h0.
  - Default program constants PROG_WORD_0..PROG_WORD_4, plus a function default_word(addr) returning the image word for any address.
- No sub-module needed.
- The default-image function can live in the package so the bench shares the same golden values.

Test Plan:
- Default fetch: rst_n pulsed low then high. Step address 0,1,2,3,4 every 10 ns with no clock edges. instruction = 20010005, 20020003, 00221820, AC030000, 8C040000, each valid before the next address change.
- Unused region: address 5, 128 and 255 after reset -> instruction = 00000000.
- Load: load_en = 1, load_addr = 10, load_data = DEADBEEF, one rising edge; then address = 10 -> DEADBEEF. Address 9 and 11 remain 00000000.
- Read-during-write: address = 2, load_addr = 2, load_data = 12345678. instruction = 00221820 before the edge and 12345678 immediately after it.
- Reset restores: after overwriting addresses 0 and 10, assert rst_n low asynchronously between clock edges. Immediately address 0 -> 20010005 and address 10 -> 00000000, with load_en held high during reset causing no write.
- Load disabled: load_en = 0 with changing load_addr/load_data over several edges -> sampled addresses 0..4 keep their default values.
